// File: rtl/mul64_word_sequencer_pkg.sv
// Shared constants and types for the 64x64 multiplier word sequencer.
// Imported by the sequencer top and its product-word selector.
package mul64_word_sequencer_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_UNLOAD = 2'd2;

  localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

  typedef logic [WORD_W-1:0] word_t;

  // True when a word index points at the final word of an operand/product.
  function automatic logic is_last(input logic [1:0] idx);
    return idx == LAST_IDX;
  endfunction

endpackage

// File: rtl/mul64_word_sequencer_mux.sv
// 4:1 product-word selector with final-word decode.
// Reusable by wider-result stages that stream a product one word at a time.
module mul64_word_mux
  import mul64_word_sequencer_pkg::*;
(
  input  logic [1:0] sel,
  input  word_t      w0,
  input  word_t      w1,
  input  word_t      w2,
  input  word_t      w3,
  output word_t      data,
  output logic       last
);

  // Select the product word addressed by the current index.
  always_comb begin
    data = '0;
    unique case (sel)
      2'd0: data = w0;
      2'd1: data = w1;
      2'd2: data = w2;
      2'd3: data = w3;
    endcase
  end

  // The final word of the product is flagged for the downstream framer.
  always_comb begin
    last = is_last(sel);
  end

endmodule

// File: rtl/mul64_word_sequencer.sv
// Word-serial loader/unloader around the 64x64 single-cycle multiplier.
// Loads four operand words, waits the multiplier latency, streams four product words.
module mul64_word_sequencer
  import mul64_word_sequencer_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      mul_a_hi,
  output logic [31:0]      mul_a_low,
  output logic [31:0]      mul_b_hi,
  output logic [31:0]      mul_b_low,
  input  logic [31:0]      mul_p_w0,
  input  logic [31:0]      mul_p_w1,
  input  logic [31:0]      mul_p_w2,
  input  logic [31:0]      mul_p_w3,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] WAIT_LAST = 4'(MUL_LATENCY - 1);

  logic [1:0] state;
  logic [1:0] idx;
  logic [3:0] wait_cnt;
  logic       in_fire;
  logic       out_fire;
  word_t      sel_data;
  logic       sel_last;

  // Handshake qualifiers derived from the current state only.
  always_comb begin
    in_ready  = (state == ST_LOAD);
    out_valid = (state == ST_UNLOAD);
    busy      = (state == ST_WAIT) || (state == ST_UNLOAD);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Operation sequencing: load four words, wait, unload four words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      idx      <= 2'd0;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            if (is_last(idx)) begin
              state    <= ST_WAIT;
              idx      <= 2'd0;
              wait_cnt <= 4'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (out_fire) begin
            if (is_last(idx)) begin
              state <= ST_LOAD;
              idx   <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: begin
          state    <= ST_LOAD;
          idx      <= 2'd0;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Operand words land in a_low, a_hi, b_low, b_hi order; frozen otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_low <= '0;
      mul_a_hi  <= '0;
      mul_b_low <= '0;
      mul_b_hi  <= '0;
    end else if (in_fire) begin
      case (idx)
        2'd0:    mul_a_low <= in_data;
        2'd1:    mul_a_hi  <= in_data;
        2'd2:    mul_b_low <= in_data;
        default: mul_b_hi  <= in_data;
      endcase
    end
  end

  // Count operations whose final product word has been taken downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire && is_last(idx)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  mul64_word_mux u_mux (
    .sel  (idx),
    .w0   (mul_p_w0),
    .w1   (mul_p_w1),
    .w2   (mul_p_w2),
    .w3   (mul_p_w3),
    .data (sel_data),
    .last (sel_last)
  );

  // Product word is a straight mux; the last flag only means something while unloading.
  always_comb begin
    out_data = sel_data;
    out_last = sel_last && (state == ST_UNLOAD);
  end

endmodule

// File: tb/tb_mul64_word_sequencer.sv
// Directed bench for mul64_word_sequencer with a latency-accurate multiplier model.
// Expected product words are queued at issue and checked by an independent monitor.
module tb_mul64_word_sequencer;

  localparam int MUL_L = 3;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   mul_a_hi, mul_a_low, mul_b_hi, mul_b_low;
  logic [31:0]   mul_p_w0, mul_p_w1, mul_p_w2, mul_p_w3;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] op_count;

  logic drv_ready = 1'b1;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  int words_seen = 0;
  int exp_ops = 0;
  int cyc = 0;

  logic [32:0]  exp_q[$];
  logic [127:0] pipe[MUL_L];
  logic [127:0] prod_now;

  assign out_ready = rnd_mode ? rnd_bit : drv_ready;

  mul64_word_sequencer #(
    .MUL_LATENCY(MUL_L),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mul_a_hi(mul_a_hi),
    .mul_a_low(mul_a_low),
    .mul_b_hi(mul_b_hi),
    .mul_b_low(mul_b_low),
    .mul_p_w0(mul_p_w0),
    .mul_p_w1(mul_p_w1),
    .mul_p_w2(mul_p_w2),
    .mul_p_w3(mul_p_w3),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // Multiplier model: MUL_L register stages after the operand inputs.
  assign prod_now = 128'({mul_a_hi, mul_a_low}) * 128'({mul_b_hi, mul_b_low});
  always @(posedge clk) begin
    pipe[0] <= prod_now;
    for (int i = 1; i < MUL_L; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p_w0 = pipe[MUL_L-1][31:0];
  assign mul_p_w1 = pipe[MUL_L-1][63:32];
  assign mul_p_w2 = pipe[MUL_L-1][95:64];
  assign mul_p_w3 = pipe[MUL_L-1][127:96];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output word is compared with the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        chk("out_word", {95'd0, out_last, out_data}, {95'd0, exp_q.pop_front()});
      end
      words_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    bit hs;
    bit ok;
    ok = 1'b0;
    if (rnd) repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("in_timeout", 128'(ok), 128'd1);
  endtask

  task automatic push_exp(input logic [127:0] p);
    exp_q.push_back({1'b0, p[31:0]});
    exp_q.push_back({1'b0, p[63:32]});
    exp_q.push_back({1'b0, p[95:64]});
    exp_q.push_back({1'b1, p[127:96]});
    exp_ops++;
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] p, input bit rnd);
    push_exp(p);
    send_word(a[31:0], rnd);
    send_word(a[63:32], rnd);
    send_word(b[31:0], rnd);
    send_word(b[63:32], rnd);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      if (op_count == CW'(exp_ops) && exp_q.size() == 0) break;
      tick();
    end
    chk({name, "_op_count"}, 128'(op_count), 128'(CW'(exp_ops)));
    chk({name, "_drained"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({name, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({name, "_out_last"}, 128'(out_last), 128'd0);
    chk({name, "_busy"}, 128'(busy), 128'd0);
    chk({name, "_op_count"}, 128'(op_count), 128'd0);
    chk({name, "_operands"},
        {mul_a_hi, mul_a_low, mul_b_hi, mul_b_low}, 128'd0);
  endtask

  task automatic do_reset(input string name);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    exp_ops = 0;
    #1;
    check_reset_vals(name);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    #1;
    check_reset_vals("reset");
    tick();
    tick();
    rst = 1'b0;

    // 2^32 * 2^32 = 2^64
    do_op(64'h00000001_00000000, 64'h00000001_00000000,
          128'h00000000_00000001_00000000_00000000, 1'b0);
    wait_done("pow2");

    // (2^64-1)^2 with the first-valid latency measured from the 4th handshake
    do_op(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
          128'hFFFFFFFF_FFFFFFFE_00000000_00000001, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("latency_edges", 128'(n), 128'(MUL_L));
    wait_done("allones");

    // Backpressure at index 1
    drv_ready = 1'b0;
    do_op(64'd3, 64'd5, 128'd15, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    drv_ready = 1'b1;
    tick();
    drv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", 128'(out_data), 128'd0);
      chk("bp_last", 128'(out_last), 128'd0);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
    end
    drv_ready = 1'b1;
    wait_done("bp");

    // Input held valid through WAIT/UNLOAD must not be taken
    do_op(64'd6, 64'd7, 128'd42, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    n = 0;
    while (busy && n < 100) begin
      chk("ign_in_ready", 128'(in_ready), 128'd0);
      chk("ign_operands", {mul_a_hi, mul_a_low, mul_b_hi, mul_b_low},
          {32'd0, 32'd6, 32'd0, 32'd7});
      tick();
      n++;
    end
    push_exp(128'h1_BD5B7DDE);
    send_word(32'hDEADBEEF, 1'b0);
    chk("ign_a_low", 128'(mul_a_low), 128'hDEADBEEF);
    send_word(32'd0, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd0, 1'b0);
    wait_done("ign");

    // Reset after two input words
    send_word(32'd9, 1'b0);
    send_word(32'd9, 1'b0);
    do_reset("rst_load");
    do_op(64'd2, 64'd7, 128'd14, 1'b0);
    wait_done("post_rst_load");

    // Reset after two output words
    base = words_seen;
    do_op(64'd2, 64'd7, 128'd14, 1'b0);
    n = 0;
    while (words_seen < base + 2 && n < 100) begin
      tick();
      n++;
    end
    drv_ready = 1'b0;
    do_reset("rst_unload");
    drv_ready = 1'b1;
    do_op(64'd2, 64'd7, 128'd14, 1'b0);
    wait_done("post_rst_unload");

    // Three back-to-back operations with random gaps on both streams
    do_reset("pre_b2b");
    rnd_mode = 1'b1;
    do_op(64'h12345678, 64'h10, 128'h1_23456780, 1'b1);
    do_op(64'hFFFFFFFF_FFFFFFFF, 64'd2,
          128'h1_FFFFFFFF_FFFFFFFE, 1'b1);
    do_op(64'h1_00000001, 64'h1_00000001,
          128'h1_00000002_00000001, 1'b1);
    wait_done("b2b");
    chk("b2b_count", 128'(op_count), 128'd3);
    rnd_mode = 1'b0;

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
